// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator scheduler: op codes, FSM states and widths.
package cmp_pkg;

  localparam int CMP_W = 16;

  localparam logic [1:0] OP_EQ = 2'b01;
  localparam logic [1:0] OP_NE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } stateT;

  // Only EQ and NE select a comparator mode; 00 and 11 are rejected with err.
  function automatic logic opLegal(input logic [1:0] op);
    return (op == OP_EQ) || (op == OP_NE);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational; the caller owns the pointer.
module rr_arb2
  import cmp_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gntIdx
);

  always_comb begin
    gnt    = 2'b00;
    gntIdx = 1'b0;
    unique case (req)
      2'b01: begin
        gnt    = 2'b01;
        gntIdx = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gntIdx = 1'b1;
      end
      2'b11: begin
        // On a tie the port that did not win last time goes next.
        gntIdx = ~last;
        gnt    = last ? 2'b01 : 2'b10;
      end
      default: begin
        gnt    = 2'b00;
        gntIdx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cmp_sched.sv
// Shares one equality comparator between two requesters: grant, drive one cycle,
// capture the result, then pulse done to the granted port.
module cmp_sched
  import cmp_pkg::*;
#(
  parameter int W       = CMP_W,
  parameter bit RR_INIT = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         req0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  output logic         done0,
  output logic         res0,
  output logic         err0,
  input  logic         req1,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         done1,
  output logic         res1,
  output logic         err1,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  output logic         cmp_eq,
  output logic         cmp_nq,
  input  logic         cmp_r,
  output logic         busy
);

  stateT        stateReg, stateNext;
  logic         lastReg;
  logic [1:0]   opReg;
  logic [W-1:0] aReg, bReg;
  logic [1:0]   resReg;
  logic [1:0]   doneVec, errVec;
  logic [1:0]   reqVec, arbGnt, selVec;
  logic         arbIdx, accept, opOk;

  assign reqVec = {req1, req0};
  assign accept = (stateReg == S_IDLE) && (|arbGnt);
  assign opOk   = opLegal(opReg);
  // lastReg doubles as the in-flight port index once an op is latched.
  assign selVec = {lastReg, ~lastReg};

  rr_arb2 uArb (
    .req    (reqVec),
    .last   (lastReg),
    .gnt    (arbGnt),
    .gntIdx (arbIdx)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stateReg <= S_IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      S_IDLE:  if (|arbGnt) stateNext = S_GRANT;
      S_GRANT: stateNext = S_RESP;
      S_RESP:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lastReg <= RR_INIT;
      opReg   <= 2'b00;
      aReg    <= '0;
      bReg    <= '0;
    end else if (accept) begin
      lastReg <= arbIdx;
      opReg   <= arbIdx ? op1 : op0;
      aReg    <= arbIdx ? a1 : a0;
      bReg    <= arbIdx ? b1 : b0;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : genRes
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          resReg[gi] <= 1'b0;
        end else if ((stateReg == S_GRANT) && selVec[gi]) begin
          resReg[gi] <= opOk & cmp_r;
        end
      end
    end
  endgenerate

  // Mode selects come straight from a one-hot decode of opReg, so they can never overlap.
  always_comb begin
    cmp_a   = '0;
    cmp_b   = '0;
    cmp_eq  = 1'b0;
    cmp_nq  = 1'b0;
    busy    = 1'b0;
    doneVec = 2'b00;
    errVec  = 2'b00;
    unique case (stateReg)
      S_GRANT: begin
        busy   = 1'b1;
        cmp_a  = aReg;
        cmp_b  = bReg;
        cmp_eq = (opReg == OP_EQ);
        cmp_nq = (opReg == OP_NE);
      end
      S_RESP: begin
        busy    = 1'b1;
        doneVec = selVec;
        errVec  = selVec & {2{~opOk}};
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign done0 = doneVec[0];
  assign done1 = doneVec[1];
  assign err0  = errVec[0];
  assign err1  = errVec[1];
  assign res0  = resReg[0];
  assign res1  = resReg[1];

endmodule

// File: doc/cmp_sched.md
Name: cmp_sched

Overview:
- Arbitrates and sequences the shared 16-bit equality comparator between two requesters.
  - Port 0: branch-resolution logic.
  - Port 1: secondary/loop-control unit.
- Registers the grant, drives the comparator's operand and mode controls for one cycle, captures the result, and returns it on a done pulse.
- Guarantees the comparator never sees both mode controls high at once.

Parameters:
- W, 16, operand width; must match the comparator operand width.
- RR_INIT, 1, initial value of the last-granted pointer at reset (1 means port 0 wins the first tie).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- req0  input  1  port 0 request level.
- op0  input  2  port 0 operation: 01 = EQ, 10 = NE, 00/11 illegal.
- a0  input  W  port 0 operand A.
- b0  input  W  port 0 operand B.
- done0  output  1  one-cycle pulse; res0/err0 valid.
- res0  output  1  port 0 compare result, held until the next port 0 done.
- err0  output  1  one-cycle pulse with done0 when op0 was illegal.
- req1, op1, a1, b1, done1, res1, err1: same as port 0, for port 1.
- cmp_a  output  W  to comparator A.
- cmp_b  output  W  to comparator B.
- cmp_eq  output  1  to comparator equality-mode select.
- cmp_nq  output  1  to comparator inequality-mode select.
- cmp_r  input  1  comparator result, combinational from cmp_a/cmp_b/cmp_eq/cmp_nq.
- busy  output  1  high in GRANT and RESP.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low (RESET_N).
  - While RESET_N=0, all outputs are 0, state is IDLE and last-granted pointer = RR_INIT.
- State machine: IDLE -> GRANT -> RESP -> IDLE.
- IDLE:
  - If exactly one req is high, latch that port.
  - If both are high, latch the port not equal to the last-granted pointer.
  - On latching: copy its op/a/b into internal registers, update the pointer, go to GRANT.
  - No req: stay in IDLE.
- GRANT (1 cycle):
  - cmp_a/cmp_b driven from the registered operands.
  - cmp_eq=1 only for op EQ; cmp_nq=1 only for op NE.
  - For an illegal op both stay 0.
  - At the clock edge, capture cmp_r (forced 0 if op illegal) into the granted port's res register; go to RESP.
- RESP (1 cycle):
  - done of the granted port = 1.
  - err of the granted port = 1 if op was illegal.
  - cmp_* return to 0.
  - Go to IDLE.
- Outside GRANT, cmp_eq, cmp_nq, cmp_a and cmp_b are all 0.
- Invariant: cmp_eq & cmp_nq is never 1.
- Latency: request sampled in IDLE at edge N; done pulses in cycle N+2.
- Throughput: one op per 3 cycles.
- Operand stability: operands and op are registered at grant, so requesters may change them after the grant edge. The requester holds req until done.
- req deasserted during GRANT/RESP: the operation still completes and done still pulses.
- req still high in the cycle after done: treated as a new request (back-to-back ops allowed).
- Fairness: with both req held continuously, grants strictly alternate.
- res0/res1: hold their value between dones. done/err are never high for both ports in the same cycle.
- Reset mid-operation (any state): immediate return to IDLE, no done issued, outputs 0.

Decomposition:
- Shared package cmp_pkg holds:
  - op encodings OP_EQ=2'b01 and OP_NE=2'b10;
  - state encodings S_IDLE, S_GRANT, S_RESP;
  - default width constant CMP_W=16.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter.
  - Inputs: req[1:0], last pointer.
  - Outputs: one-hot grant, grant index.
  - Purely combinational; the pointer register lives in cmp_sched.

Test Plan:
- Reset, then req0 with op0=01, a0=b0=0x1234 at edge N -> cycle N+1: cmp_eq=1, cmp_nq=0, cmp_a=cmp_b=0x1234; cycle N+2: done0=1, res0=1, err0=0; busy=1 for 2 cycles.
- req1 with op1=10, a1=0xFFFF, b1=0x0000 -> done1 at N+2, res1=1; then op1=10 with a1=b1=0xABCD -> res1=0; res0 unchanged.
- req0 and req1 both asserted at edge N after reset (RR_INIT=1) -> done0 at N+2, done1 at N+5; both held high -> grant order 0,1,0,1 over 12 cycles.
- req0 with op0=11 -> cmp_eq=cmp_nq=0 in GRANT; done0 and err0 pulse together at N+2, res0=0.
- RESET_N pulled low during GRANT -> same cycle: all outputs 0, no done; after release, req1 alone -> done1 at 2 cycles after acceptance.
- Throughout all tests, assertion: cmp_eq & cmp_nq never high, and done0 & done1 never high together.
